icache_dm: RTL and testbench
============================

Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache between the CPU fetch port (mapped fetch address, fetch request, uncached flag, fetched word, fetch stall) and the memory bus.
- Hits return the instruction combinationally in the request cycle.
- Misses assert stall and refill a full line by burst. Uncached (I/O) fetches bypass the arrays as single-word reads.
- The EX-stage cache-op strobe invalidates one line by address.

Parameters:
INDEX_BITS, 7, line index width (2^INDEX_BITS lines)
OFFSET_BITS, 3, word-offset width (2^OFFSET_BITS words per line)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
addr  input  32  physical fetch address; bits [1:0] ignored
req  input  1  fetch request
io  input  1  fetch is uncached
hold  input  1  CPU pipeline stalled by another source; word not consumed
inst  output  32  fetched instruction
stall  output  1  fetch not yet served
inv  input  1  invalidate line strobe
inv_addr  input  32  physical address selecting the line to invalidate
mem_addr  output  32  bus address, word aligned
mem_req  output  1  bus read request, held for the whole transfer
mem_burst  output  1  1 = line burst of 2^OFFSET_BITS words, 0 = single word
mem_rvalid  input  1  one data word valid this cycle
mem_data  input  32  bus read data

Behaviour:
- Address split:
  - offset = addr[OFFSET_BITS+1:2]
  - index = next INDEX_BITS bits
  - tag = addr[31:INDEX_BITS+OFFSET_BITS+2]
- Storage:
  - valid bits in flops.
  - tag and data arrays have asynchronous read and synchronous write.
- hit = req & ~io & valid[index] & (tag_arr[index] == tag).
- FSM states: IDLE, REFILL, UNC, UDONE.
- IDLE:
  - req=0 → stall=0, inst=0.
  - hit → stall=0, inst=data[index][offset]; zero latency.
  - req & ~io & ~hit → stall=1 same cycle; latch line base {addr[31:OFFSET_BITS+2], 0}; word counter=0; next state REFILL.
  - req & io → stall=1; latch addr; next state UNC.
- REFILL:
  - Drive mem_req=1, mem_burst=1, mem_addr=line base, stall=1.
  - Each mem_rvalid writes mem_data to data[index][counter] and increments counter.
  - On the last word: write tag, set valid, go IDLE. The next cycle hits (miss penalty = burst time + 1 cycle).
  - The CPU holds addr during stall; a changed addr is not supported.
- UNC:
  - Drive mem_req=1, mem_burst=0, mem_addr={addr[31:2],2'b00}, stall=1.
  - On mem_rvalid, latch mem_data into the uncached buffer and go UDONE. Arrays are untouched.
- UDONE:
  - stall=0, inst=uncached buffer.
  - Stay while hold=1; go IDLE when hold=0.
- Invalidate:
  - inv clears valid[inv index] at the clock edge, in any state.
  - If inv coincides with the final refill word for the same index, inv wins: the line stays invalid and the FSM goes IDLE, then misses again.
- Simultaneous hit read and inv of the same line: the current cycle still returns hit data; the line is invalid from the next cycle.
- Reset:
  - All valid cleared (loop or reset-able flops), state=IDLE, counter=0, buffer=0.
  - mem_req=0 from the cycle after rst is sampled. Dropping mem_req aborts any burst in progress, and the bus discards remaining beats.
  - Outputs during/after reset: stall=0, inst=0, mem_req=0, mem_burst=0, mem_addr=0.
- mem_rvalid outside REFILL/UNC is ignored.

Test Plan:
- Cold miss:
  - Stimulus: after reset, req=1, io=0, addr=0x0000_1040; bus returns 8 words 0xA0..0xA7, 1 per cycle.
  - Response: stall=1 from the first cycle; mem_addr=0x1040, mem_burst=1; the cycle after the 8th beat stall=0, inst=0xA0.
- Hits:
  - Stimulus: addr=0x105C, then 0x1044.
  - Response: stall=0 same cycle, inst=0xA7 then 0xA1; no mem_req.
- Conflict eviction:
  - Stimulus: addr=0x2040 (same index, tag differs).
  - Response: refill at mem_addr=0x2040; afterwards 0x1040 misses again.
- Uncached fetch with hold:
  - Stimulus: io=1, addr=0x1FC0_0004; bus returns 0xDEADBEEF; hold=1 for 3 cycles.
  - Response: mem_burst=0, mem_addr=0x1FC0_0004; inst=0xDEADBEEF with stall=0 for all 3 hold cycles; the arrays are unchanged, so 0x1040 still follows its cached valid/tag state.
- Invalidate:
  - Stimulus: inv=1, inv_addr=0x1048 while line 0x1040 is valid.
  - Response: the next req to 0x1044 misses and refills. inv on the final refill beat of the same index → the line is still invalid and misses again.
- Reset mid-refill:
  - Stimulus: assert rst after 3 of 8 beats.
  - Response: mem_req=0 next cycle, stall=0; req to the same address afterwards performs a full fresh refill from word 0.

Source files
------------

// File: rtl/icache_dm_if.sv
// Fetch-port and memory-bus signal bundle for the direct-mapped instruction cache.
// The slave modport is the cache view; the master modport is the CPU/bus side.
interface icache_dm_if;
  logic [31:0] addr;
  logic        req;
  logic        io;
  logic        hold;
  logic [31:0] inst;
  logic        stall;
  logic        inv;
  logic [31:0] inv_addr;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic        mem_burst;
  logic        mem_rvalid;
  logic [31:0] mem_data;

  modport slave (
    input  addr, req, io, hold, inv, inv_addr, mem_rvalid, mem_data,
    output inst, stall, mem_addr, mem_req, mem_burst
  );

  modport master (
    output addr, req, io, hold, inv, inv_addr, mem_rvalid, mem_data,
    input  inst, stall, mem_addr, mem_req, mem_burst
  );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: zero-latency hits, burst line refill,
// single-word uncached bypass and per-line invalidate.
//
// state  | meaning
// IDLE   | serve hits; launch refill on miss or bypass read on uncached fetch
// REFILL | burst the missing line from the bus into the arrays
// UNC    | single-word uncached read in flight
// UDONE  | uncached word presented until the pipeline consumes it (hold=0)
module icache_dm #(
  parameter int INDEX_BITS  = 7,
  parameter int OFFSET_BITS = 3
) (
  input logic        clk,
  input logic        rst,
  icache_dm_if.slave bus
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int WORDS    = 1 << OFFSET_BITS;
  localparam int IDX_LO   = OFFSET_BITS + 2;
  localparam int TAG_LO   = INDEX_BITS + OFFSET_BITS + 2;
  localparam int TAG_BITS = 32 - TAG_LO;

  typedef enum logic [1:0] {IDLE, REFILL, UNC, UDONE} state_t;

  state_t state, state_nxt;

  logic [LINES-1:0]       valid;
  logic [TAG_BITS-1:0]    tag_arr  [LINES];
  logic [31:0]            data_arr [LINES*WORDS];

  logic [31:0]            line_base;
  logic [31:0]            unc_addr;
  logic [31:0]            unc_buf;
  logic [OFFSET_BITS-1:0] cnt;

  logic [OFFSET_BITS-1:0] offset;
  logic [INDEX_BITS-1:0]  index;
  logic [TAG_BITS-1:0]    tag;
  logic [INDEX_BITS-1:0]  ref_index;
  logic [TAG_BITS-1:0]    ref_tag;
  logic [INDEX_BITS-1:0]  inv_index;

  logic                   hit;
  logic                   beat;
  logic                   last_beat;
  logic                   miss_start;
  logic                   unc_start;

  logic [31:0]            inst;
  logic                   stall;
  logic [31:0]            mem_addr;
  logic                   mem_req;
  logic                   mem_burst;

  assign offset    = bus.addr[OFFSET_BITS+1:2];
  assign index     = bus.addr[IDX_LO +: INDEX_BITS];
  assign tag       = bus.addr[31:TAG_LO];
  assign ref_index = line_base[IDX_LO +: INDEX_BITS];
  assign ref_tag   = line_base[31:TAG_LO];
  assign inv_index = bus.inv_addr[IDX_LO +: INDEX_BITS];

  assign hit       = bus.req & ~bus.io & valid[index] & (tag_arr[index] == tag);
  assign beat      = (state == REFILL) & bus.mem_rvalid;
  assign last_beat = beat & (&cnt);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    stall      = 1'b0;
    inst       = '0;
    mem_req    = 1'b0;
    mem_burst  = 1'b0;
    mem_addr   = '0;
    miss_start = 1'b0;
    unc_start  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req) begin
          if (bus.io) begin
            stall     = 1'b1;
            unc_start = 1'b1;
            state_nxt = UNC;
          end else if (hit) begin
            inst = data_arr[{index, offset}];
          end else begin
            stall      = 1'b1;
            miss_start = 1'b1;
            state_nxt  = REFILL;
          end
        end
      end
      REFILL: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_burst = 1'b1;
        mem_addr  = line_base;
        if (last_beat) state_nxt = IDLE;
      end
      UNC: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {unc_addr[31:2], 2'b00};
        if (bus.mem_rvalid) state_nxt = UDONE;
      end
      UDONE: begin
        inst = unc_buf;
        if (!bus.hold) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Quiet bus and fetch port for the whole reset cycle, whatever state we came from.
    if (rst) begin
      stall     = 1'b0;
      inst      = '0;
      mem_req   = 1'b0;
      mem_burst = 1'b0;
      mem_addr  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid     <= '0;
      cnt       <= '0;
      line_base <= '0;
      unc_addr  <= '0;
      unc_buf   <= '0;
    end else begin
      if (miss_start) begin
        line_base <= {bus.addr[31:IDX_LO], {IDX_LO{1'b0}}};
        cnt       <= '0;
      end
      if (unc_start) unc_addr <= bus.addr;
      if (beat) cnt <= cnt + 1'b1;
      if ((state == UNC) && bus.mem_rvalid) unc_buf <= bus.mem_data;
      if (last_beat) valid[ref_index] <= 1'b1;
      // Placed last so an invalidate on the final refill beat leaves the line invalid.
      if (bus.inv) valid[inv_index] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && beat) data_arr[{ref_index, cnt}] <= bus.mem_data;
    if (!rst && last_beat) tag_arr[ref_index] <= ref_tag;
  end

  assign bus.inst      = inst;
  assign bus.stall     = stall;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_req   = mem_req;
  assign bus.mem_burst = mem_burst;

  logic unused_bits;
  assign unused_bits = ^{bus.addr[1:0], bus.inv_addr[31:TAG_LO], bus.inv_addr[IDX_LO-1:0],
                         line_base[IDX_LO-1:0], unc_addr[1:0]};

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: cold miss, hits, conflict eviction, uncached
// fetch with hold, invalidate (incl. on the final refill beat) and reset mid-refill.
module tb_icache_dm;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  icache_dm_if bus ();

  icache_dm #(.INDEX_BITS(7), .OFFSET_BITS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int tests  = 0;
  int failed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Eight one-per-cycle beats d0..d0+7; optional invalidate on the last beat.
  task automatic burst(input string tag, input logic [31:0] base, input logic [31:0] d0,
                       input bit inv_last, input logic [31:0] ia);
    for (int i = 0; i < 8; i++) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_data   = d0 + i;
      if (inv_last && i == 7) begin
        bus.inv      = 1'b1;
        bus.inv_addr = ia;
      end
      #1;
      if (i == 0) begin
        chk({tag, "_mem_req"},   {31'b0, bus.mem_req},   32'd1);
        chk({tag, "_mem_burst"}, {31'b0, bus.mem_burst}, 32'd1);
        chk({tag, "_mem_addr"},  bus.mem_addr,           base);
      end
      if (i == 7) chk({tag, "_stall_last"}, {31'b0, bus.stall}, 32'd1);
      tick();
    end
    bus.mem_rvalid = 1'b0;
    bus.mem_data   = '0;
    bus.inv        = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    bus.addr       = '0;
    bus.req        = 1'b0;
    bus.io         = 1'b0;
    bus.hold       = 1'b0;
    bus.inv        = 1'b0;
    bus.inv_addr   = '0;
    bus.mem_rvalid = 1'b0;
    bus.mem_data   = '0;
    tick();
    tick();
    chk("rst_stall",     {31'b0, bus.stall},     32'd0);
    chk("rst_inst",      bus.inst,               32'd0);
    chk("rst_mem_req",   {31'b0, bus.mem_req},   32'd0);
    chk("rst_mem_burst", {31'b0, bus.mem_burst}, 32'd0);
    chk("rst_mem_addr",  bus.mem_addr,           32'd0);
    rst = 1'b0;
    tick();

    // cold miss on 0x1040 (index 2, tag 1)
    bus.req  = 1'b1;
    bus.addr = 32'h0000_1040;
    #1;
    chk("cold_stall", {31'b0, bus.stall},   32'd1);
    chk("cold_noreq", {31'b0, bus.mem_req}, 32'd0);
    tick();
    burst("cold", 32'h0000_1040, 32'hA0, 1'b0, 32'h0);
    #1;
    chk("cold_hit_stall", {31'b0, bus.stall}, 32'd0);
    chk("cold_hit_inst",  bus.inst,           32'hA0);
    tick();

    // hits on words 7 and 1; a stray rvalid in IDLE must be ignored
    bus.addr = 32'h0000_105C;
    #1;
    chk("hit7_stall", {31'b0, bus.stall},   32'd0);
    chk("hit7_inst",  bus.inst,             32'hA7);
    chk("hit7_noreq", {31'b0, bus.mem_req}, 32'd0);
    tick();
    bus.addr       = 32'h0000_1044;
    bus.mem_rvalid = 1'b1;
    bus.mem_data   = 32'hFFFF_FFFF;
    #1;
    chk("hit1_inst",  bus.inst,             32'hA1);
    chk("hit1_noreq", {31'b0, bus.mem_req}, 32'd0);
    tick();
    bus.mem_rvalid = 1'b0;
    bus.mem_data   = '0;
    #1;
    chk("hit1_again", bus.inst, 32'hA1);
    tick();

    // conflict eviction by 0x2040 (same index, tag 2)
    bus.addr = 32'h0000_2040;
    #1;
    chk("evict_stall", {31'b0, bus.stall}, 32'd1);
    tick();
    burst("evict", 32'h0000_2040, 32'hB0, 1'b0, 32'h0);
    #1;
    chk("evict_inst", bus.inst, 32'hB0);
    tick();
    bus.addr = 32'h0000_1040;
    #1;
    chk("remiss_stall", {31'b0, bus.stall}, 32'd1);
    tick();
    burst("remiss", 32'h0000_1040, 32'hC0, 1'b0, 32'h0);
    #1;
    chk("remiss_inst", bus.inst, 32'hC0);
    tick();

    // uncached fetch held for three cycles
    bus.io   = 1'b1;
    bus.addr = 32'h1FC0_0004;
    #1;
    chk("unc_stall0", {31'b0, bus.stall}, 32'd1);
    tick();
    chk("unc_mem_req",   {31'b0, bus.mem_req},   32'd1);
    chk("unc_mem_burst", {31'b0, bus.mem_burst}, 32'd0);
    chk("unc_mem_addr",  bus.mem_addr,           32'h1FC0_0004);
    chk("unc_stall1",    {31'b0, bus.stall},     32'd1);
    bus.mem_rvalid = 1'b1;
    bus.mem_data   = 32'hDEAD_BEEF;
    bus.hold       = 1'b1;
    tick();
    bus.mem_rvalid = 1'b0;
    bus.mem_data   = '0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("unc_hold_stall", {31'b0, bus.stall},   32'd0);
      chk("unc_hold_inst",  bus.inst,             32'hDEAD_BEEF);
      chk("unc_hold_noreq", {31'b0, bus.mem_req}, 32'd0);
      tick();
    end
    bus.hold = 1'b0;
    #1;
    chk("unc_release_inst", bus.inst, 32'hDEAD_BEEF);
    tick();

    // arrays untouched; hit while invalidating the same line still returns data
    bus.io       = 1'b0;
    bus.addr     = 32'h0000_1040;
    bus.inv      = 1'b1;
    bus.inv_addr = 32'h0000_1048;
    #1;
    chk("post_unc_stall", {31'b0, bus.stall}, 32'd0);
    chk("post_unc_inst",  bus.inst,           32'hC0);
    tick();
    bus.inv  = 1'b0;
    bus.addr = 32'h0000_1044;
    #1;
    chk("inv_miss_stall", {31'b0, bus.stall}, 32'd1);
    tick();
    burst("invlast", 32'h0000_1040, 32'hD0, 1'b1, 32'h0000_1048);
    #1;
    chk("invlast_stall", {31'b0, bus.stall},   32'd1);
    chk("invlast_noreq", {31'b0, bus.mem_req}, 32'd0);
    tick();
    burst("refill3", 32'h0000_1040, 32'hE0, 1'b0, 32'h0);
    #1;
    chk("refill3_inst", bus.inst, 32'hE1);
    tick();

    // reset after three of eight beats
    bus.addr = 32'h0000_3040;
    #1;
    chk("mid_stall", {31'b0, bus.stall}, 32'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_data   = 32'hF0 + i;
      tick();
    end
    bus.mem_rvalid = 1'b0;
    bus.mem_data   = '0;
    rst = 1'b1;
    #1;
    chk("mid_rst_mem_req", {31'b0, bus.mem_req}, 32'd0);
    chk("mid_rst_stall",   {31'b0, bus.stall},   32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_mem_req", {31'b0, bus.mem_req}, 32'd0);
    chk("post_rst_stall",   {31'b0, bus.stall},   32'd1);
    tick();
    burst("fresh", 32'h0000_3040, 32'h70, 1'b0, 32'h0);
    #1;
    chk("fresh_w0", bus.inst, 32'h70);
    tick();
    bus.addr = 32'h0000_305C;
    #1;
    chk("fresh_w7", bus.inst, 32'h77);
    tick();
    bus.req = 1'b0;
    #1;
    chk("idle_inst", bus.inst, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
